// File: rtl/feature_mem_streamer.sv
// feature_mem_streamer
// Sweeps the 4-bank feature memory once its write phase is complete and
// re-serialises the four bank words of each address into one in-order
// feature stream: feature k comes from bank (k % 4) at address (k / 4).
//
// Stream handshake: a feature transfers on any rising clock edge where
// feat_valid and feat_ready are both high. Once feat_valid is raised it stays
// high, and feat_out / feat_idx / feat_last stay unchanged, until that
// transfer happens. feat_ready may toggle freely and never feeds back into
// the data outputs.
module feature_mem_streamer #(
  parameter int Div_SIZE    = 512,
  parameter int INOUT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RD_LAT      = 1,
  parameter int IDX_WIDTH   = $clog2(Div_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mem_ready,
  output logic [ADDR_WIDTH-1:0]  read_address,
  output logic                   re,
  input  logic [INOUT_WIDTH-1:0] in0,
  input  logic [INOUT_WIDTH-1:0] in1,
  input  logic [INOUT_WIDTH-1:0] in2,
  input  logic [INOUT_WIDTH-1:0] in3,
  output logic [INOUT_WIDTH-1:0] feat_out,
  output logic [IDX_WIDTH-1:0]   feat_idx,
  output logic                   feat_valid,
  input  logic                   feat_ready,
  output logic                   feat_last,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Latency counter only needs to count 0..RD_LAT-1
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(Div_SIZE / 4 - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(Div_SIZE - 1);

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [1:0]             lane_q;
  logic [LAT_W-1:0]       lat_q;
  logic [INOUT_WIDTH-1:0] hold_q [4];
  logic                   busy_q;

  logic start_ok;
  logic handshake;
  logic lat_hit;
  logic group_end;
  logic sweep_end;

  assign start_ok  = (state_q == S_IDLE) && start && mem_ready;
  assign handshake = (state_q == S_EMIT) && feat_ready;
  assign lat_hit   = (state_q == S_WAIT) && (lat_q == LAT_LAST);
  assign group_end = handshake && (lane_q == 2'd3);
  assign sweep_end = group_end && (addr_q == LAST_ADDR);

  // Next-state decode for the sweep sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_READ;
      S_READ: state_d = S_WAIT;
      S_WAIT: if (lat_hit) state_d = S_EMIT;
      S_EMIT: begin
        if (group_end) state_d = sweep_end ? S_DONE : S_READ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Address counter: cleared on an accepted start, stepped after each group
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if (start_ok) begin
      addr_q <= '0;
    end else if (group_end && !sweep_end) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  // Read-latency counter: counts WAIT cycles since the READ cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
    end else if (state_q == S_READ) begin
      lat_q <= '0;
    end else if ((state_q == S_WAIT) && !lat_hit) begin
      lat_q <= lat_q + LAT_W'(1);
    end
  end

  // Bank capture: the memory outputs are sampled only here, RD_LAT cycles
  // after the read was issued, so the banks are free to change afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
    end else if (lat_hit) begin
      hold_q[0] <= in0;
      hold_q[1] <= in1;
      hold_q[2] <= in2;
      hold_q[3] <= in3;
    end
  end

  // Lane pointer: restarts at 0 for each group, advances on each transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= 2'd0;
    end else if (lat_hit) begin
      lane_q <= 2'd0;
    end else if (handshake) begin
      lane_q <= lane_q + 2'd1;
    end
  end

  // Busy flag: set on an accepted start, dropped as DONE hands back to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else if (start_ok) begin
      busy_q <= 1'b1;
    end else if (state_q == S_DONE) begin
      busy_q <= 1'b0;
    end
  end

  // Output decode; data outputs are forced to zero whenever not valid
  always_comb begin
    re           = (state_q == S_READ);
    read_address = addr_q;
    feat_valid   = (state_q == S_EMIT);
    feat_out     = '0;
    feat_idx     = '0;
    if (feat_valid) begin
      feat_out = hold_q[lane_q];
      feat_idx = IDX_WIDTH'({addr_q, lane_q});
    end
    feat_last = feat_valid && (feat_idx == LAST_IDX);
    busy      = busy_q;
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_feature_mem_streamer.sv
// Bench for feature_mem_streamer. Instance a uses RD_LAT=1, instance b uses
// RD_LAT=2; each has its own bank model preloaded with feature k = k.
module tb_feature_mem_streamer;

  localparam int DIV   = 512;
  localparam int W     = 32;
  localparam int AW    = 8;
  localparam int IW    = 9;
  localparam int NADDR = DIV / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance a (RD_LAT=1) ----------------
  logic          a_start = 1'b0;
  logic          a_mem_ready = 1'b0;
  logic [AW-1:0] a_read_address;
  logic          a_re;
  logic [W-1:0]  a_mem [4];
  logic [W-1:0]  a_feat_out;
  logic [IW-1:0] a_feat_idx;
  logic          a_feat_valid;
  logic          a_feat_ready = 1'b1;
  logic          a_feat_last;
  logic          a_busy;
  logic          a_done;
  logic [2:0]    a_dbg_state;

  feature_mem_streamer #(
    .Div_SIZE(DIV), .INOUT_WIDTH(W), .ADDR_WIDTH(AW), .RD_LAT(1), .IDX_WIDTH(IW)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .mem_ready(a_mem_ready),
    .read_address(a_read_address), .re(a_re),
    .in0(a_mem[0]), .in1(a_mem[1]), .in2(a_mem[2]), .in3(a_mem[3]),
    .feat_out(a_feat_out), .feat_idx(a_feat_idx), .feat_valid(a_feat_valid),
    .feat_ready(a_feat_ready), .feat_last(a_feat_last),
    .busy(a_busy), .done(a_done), .dbg_state(a_dbg_state)
  );

  // bank model, one-cycle read latency
  always @(posedge clk) begin
    if (a_re) begin
      for (int i = 0; i < 4; i++) a_mem[i] <= W'(int'(a_read_address) * 4 + i);
    end
  end

  // ---------------- instance b (RD_LAT=2) ----------------
  logic          b_start = 1'b0;
  logic          b_mem_ready = 1'b0;
  logic [AW-1:0] b_read_address;
  logic          b_re;
  logic [W-1:0]  b_s1 [4];
  logic [W-1:0]  b_mem [4];
  logic [W-1:0]  b_feat_out;
  logic [IW-1:0] b_feat_idx;
  logic          b_feat_valid;
  logic          b_feat_ready = 1'b1;
  logic          b_feat_last;
  logic          b_busy;
  logic          b_done;
  logic [2:0]    b_dbg_state;

  feature_mem_streamer #(
    .Div_SIZE(DIV), .INOUT_WIDTH(W), .ADDR_WIDTH(AW), .RD_LAT(2), .IDX_WIDTH(IW)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .mem_ready(b_mem_ready),
    .read_address(b_read_address), .re(b_re),
    .in0(b_mem[0]), .in1(b_mem[1]), .in2(b_mem[2]), .in3(b_mem[3]),
    .feat_out(b_feat_out), .feat_idx(b_feat_idx), .feat_valid(b_feat_valid),
    .feat_ready(b_feat_ready), .feat_last(b_feat_last),
    .busy(b_busy), .done(b_done), .dbg_state(b_dbg_state)
  );

  // bank model, two-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (b_re) b_s1[i] <= W'(int'(b_read_address) * 4 + i);
      b_mem[i] <= b_s1[i];
    end
  end

  // ---------------- scoreboards ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] b_exp_q[$];

  int a_hs = 0, a_done_cnt = 0, a_re_cnt = 0, a_last_cnt = 0;
  int a_busy_seen = 0, a_valid_seen = 0;
  logic          a_prev_stall = 1'b0;
  logic [W-1:0]  a_prev_out;
  logic [IW-1:0] a_prev_idx;

  int b_hs = 0, b_done_cnt = 0, b_re_cnt = 0, b_exp_addr = 0;
  logic b_prev_re = 1'b0;

  // instance a monitor: handshakes popped against expected queue, stall hold
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      a_prev_stall = 1'b0;
    end else begin
      if (a_re) a_re_cnt++;
      if (a_busy) a_busy_seen++;
      if (a_done) a_done_cnt++;
      if (a_prev_stall) begin
        checks++;
        if (a_feat_valid !== 1'b1 || a_feat_out !== a_prev_out || a_feat_idx !== a_prev_idx) begin
          failures++;
          $display("FAIL a_stall_hold: got valid=%0b out=%0d idx=%0d, need valid=1 out=%0d idx=%0d",
                   a_feat_valid, a_feat_out, a_feat_idx, a_prev_out, a_prev_idx);
        end
      end
      if (a_feat_valid) begin
        a_valid_seen++;
        checks++;
        if (a_feat_last !== (a_feat_idx == IW'(DIV - 1))) begin
          failures++;
          $display("FAIL a_last_flag: got last=%0b at idx=%0d", a_feat_last, a_feat_idx);
        end
        if (a_feat_ready) begin
          a_hs++;
          if (a_feat_last) a_last_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL a_unexpected: got out=%0d idx=%0d, need no transfer", a_feat_out, a_feat_idx);
          end else begin
            e = exp_q.pop_front();
            if (a_feat_out !== e || a_feat_idx !== IW'(e)) begin
              failures++;
              $display("FAIL a_stream: got out=%0d idx=%0d, need out=%0d idx=%0d",
                       a_feat_out, a_feat_idx, e, IW'(e));
            end
          end
        end
      end
      a_prev_stall = a_feat_valid && !a_feat_ready;
      a_prev_out   = a_feat_out;
      a_prev_idx   = a_feat_idx;
    end
  end

  // instance b monitor: stream order plus read address stepping
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      b_prev_re = 1'b0;
    end else begin
      if (b_done) b_done_cnt++;
      if (b_re) begin
        b_re_cnt++;
        checks++;
        if (b_read_address !== AW'(b_exp_addr) || b_prev_re) begin
          failures++;
          $display("FAIL b_read_addr: got addr=%0d back_to_back_re=%0b, need addr=%0d single re",
                   b_read_address, b_prev_re, b_exp_addr);
        end
        b_exp_addr++;
      end
      b_prev_re = b_re;
      if (b_feat_valid && b_feat_ready) begin
        b_hs++;
        checks++;
        if (b_exp_q.size() == 0) begin
          failures++;
          $display("FAIL b_unexpected: got out=%0d idx=%0d", b_feat_out, b_feat_idx);
        end else begin
          e = b_exp_q.pop_front();
          if (b_feat_out !== e || b_feat_idx !== IW'(e) || b_feat_last !== (e == W'(DIV - 1))) begin
            failures++;
            $display("FAIL b_stream: got out=%0d idx=%0d last=%0b, need out=%0d idx=%0d",
                     b_feat_out, b_feat_idx, b_feat_last, e, IW'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sweep_a();
    for (int k = 0; k < DIV; k++) exp_q.push_back(W'(k));
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  // runs cycles until instance a reports a new done pulse or budget expires
  task automatic run_until_done_a(input int d0, input bit rand_rdy, output bit finished);
    finished = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      if (rand_rdy) a_feat_ready = 1'($urandom_range(0, 1));
      if (a_done_cnt != d0) begin
        finished = 1'b1;
        break;
      end
    end
    a_feat_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_read_address, a_re, a_feat_out, a_feat_idx, a_feat_valid, a_feat_last, a_busy, a_done, a_dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_a: got addr=%0d re=%0b out=%0d idx=%0d v=%0b l=%0b busy=%0b done=%0b st=%0d, need all 0",
               a_read_address, a_re, a_feat_out, a_feat_idx, a_feat_valid, a_feat_last, a_busy, a_done, a_dbg_state);
    end
    checks++;
    if ({b_read_address, b_re, b_feat_out, b_feat_idx, b_feat_valid, b_feat_last, b_busy, b_done, b_dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_b: got re=%0b v=%0b busy=%0b done=%0b st=%0d, need all 0",
               b_re, b_feat_valid, b_busy, b_done, b_dbg_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_sweep();
    int n;
    bit seen, fin;
    int d0;
    a_mem_ready = 1'b1;
    a_feat_ready = 1'b1;
    a_hs = 0; a_re_cnt = 0; a_last_cnt = 0;
    d0 = a_done_cnt;
    push_sweep_a();
    @(posedge clk); #1 a_start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); n++;
      #1 a_start = 1'b0;
      @(negedge clk);
      if (a_feat_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 3) begin
      failures++;
      $display("FAIL a_first_latency: got %0d cycles (seen=%0b), need 3", n, seen);
    end
    run_until_done_a(d0, 1'b0, fin);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (!fin || a_done_cnt != d0 + 1 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL a_sweep_done: got finished=%0b done_pulses=%0d busy=%0b, need 1 pulse busy=0",
               fin, a_done_cnt - d0, a_busy);
    end
    checks++;
    if (exp_q.size() != 0 || a_hs != DIV || a_last_cnt != 1 || a_re_cnt != NADDR) begin
      failures++;
      $display("FAIL a_sweep_counts: got left=%0d hs=%0d last=%0d re=%0d, need 0 %0d 1 %0d",
               exp_q.size(), a_hs, a_last_cnt, a_re_cnt, DIV, NADDR);
    end
  endtask

  task automatic test_no_mem_ready();
    a_mem_ready = 1'b0;
    a_re_cnt = 0; a_busy_seen = 0; a_valid_seen = 0;
    pulse_start_a();
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_re_cnt != 0 || a_busy_seen != 0 || a_valid_seen != 0 || a_dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL a_no_mem_ready: got re=%0d busy=%0d valid=%0d st=%0d, need all 0",
               a_re_cnt, a_busy_seen, a_valid_seen, a_dbg_state);
    end
    a_mem_ready = 1'b1;
  endtask

  task automatic test_random_ready();
    bit fin;
    int d0;
    a_hs = 0; a_last_cnt = 0;
    d0 = a_done_cnt;
    push_sweep_a();
    pulse_start_a();
    run_until_done_a(d0, 1'b1, fin);
    repeat (3) @(posedge clk);
    checks++;
    if (!fin || exp_q.size() != 0 || a_hs != DIV || a_last_cnt != 1 || a_done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL a_random_ready: got finished=%0b left=%0d hs=%0d last=%0d done=%0d, need 1 0 %0d 1 1",
               fin, exp_q.size(), a_hs, a_last_cnt, a_done_cnt - d0, DIV);
    end
  endtask

  task automatic test_start_while_busy();
    bit fin;
    int d0;
    a_hs = 0; a_re_cnt = 0;
    d0 = a_done_cnt;
    push_sweep_a();
    pulse_start_a();
    for (int c = 0; c < 2000 && a_hs < 100; c++) begin
      @(posedge clk); #1;
    end
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int c = 0; c < 2000 && a_hs < 200; c++) begin
      @(posedge clk); #1;
    end
    a_mem_ready = 1'b0;
    run_until_done_a(d0, 1'b0, fin);
    repeat (30) @(posedge clk);
    checks++;
    if (!fin || a_done_cnt != d0 + 1 || a_re_cnt != NADDR || a_hs != DIV || exp_q.size() != 0) begin
      failures++;
      $display("FAIL a_start_busy: got finished=%0b done=%0d re=%0d hs=%0d left=%0d, need 1 1 %0d %0d 0",
               fin, a_done_cnt - d0, a_re_cnt, a_hs, exp_q.size(), NADDR, DIV);
    end
    a_mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_sweep();
    bit fin;
    int d0;
    a_hs = 0;
    d0 = a_done_cnt;
    push_sweep_a();
    pulse_start_a();
    for (int c = 0; c < 2000 && a_hs < 302; c++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_read_address, a_re, a_feat_out, a_feat_idx, a_feat_valid, a_feat_last, a_busy, a_done, a_dbg_state} !== '0) begin
      failures++;
      $display("FAIL a_async_reset: got addr=%0d re=%0b out=%0d idx=%0d v=%0b busy=%0b st=%0d, need all 0",
               a_read_address, a_re, a_feat_out, a_feat_idx, a_feat_valid, a_busy, a_dbg_state);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (a_done_cnt != d0) begin
      failures++;
      $display("FAIL a_reset_no_done: got %0d done pulses, need 0", a_done_cnt - d0);
    end
    a_hs = 0; a_last_cnt = 0;
    push_sweep_a();
    pulse_start_a();
    run_until_done_a(d0, 1'b0, fin);
    repeat (3) @(posedge clk);
    checks++;
    if (!fin || a_hs != DIV || exp_q.size() != 0 || a_last_cnt != 1) begin
      failures++;
      $display("FAIL a_restart: got finished=%0b hs=%0d left=%0d last=%0d, need 1 %0d 0 1",
               fin, a_hs, exp_q.size(), a_last_cnt, DIV);
    end
  endtask

  task automatic test_rd_lat2();
    int n;
    bit seen;
    int d0;
    b_mem_ready = 1'b1;
    b_feat_ready = 1'b1;
    b_hs = 0; b_re_cnt = 0; b_exp_addr = 0;
    d0 = b_done_cnt;
    for (int k = 0; k < DIV; k++) b_exp_q.push_back(W'(k));
    @(posedge clk); #1 b_start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); n++;
      #1 b_start = 1'b0;
      @(negedge clk);
      if (b_feat_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 4) begin
      failures++;
      $display("FAIL b_first_latency: got %0d cycles (seen=%0b), need 4", n, seen);
    end
    for (int c = 0; c < 6000 && b_done_cnt == d0; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (b_done_cnt != d0 + 1 || b_re_cnt != NADDR || b_exp_addr != NADDR || b_hs != DIV
        || b_exp_q.size() != 0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL b_sweep: got done=%0d re=%0d hs=%0d left=%0d busy=%0b, need 1 %0d %0d 0 0",
               b_done_cnt - d0, b_re_cnt, b_hs, b_exp_q.size(), b_busy, NADDR, DIV);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_full_sweep();
    test_no_mem_ready();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_rd_lat2();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
